bulk_pipe_ctrl: RTL



---
 rtl/bulk_pipe_pkg.sv | 19 +
 rtl/bulk_pipe_stage.sv | 25 ++
 rtl/bulk_pipe_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/bulk_pipe_pkg.sv
// Shared types and defaults for the bulk value/enable pipeline controller.
package bulk_pipe_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_STAGES      = 3;
  localparam int DEF_STUCK_LIMIT = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    STUCK = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] value;
    logic                 enable;
  } stage_t;

endpackage

// File: rtl/bulk_pipe_stage.sv
// One {value, enable} stage register; clear and reset both empty the stage.
module bulk_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_value,
  input  logic             d_enable,
  output logic [WIDTH-1:0] q_value,
  output logic             q_enable
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      q_value  <= '0;
      q_enable <= 1'b0;
    end else if (load) begin
      q_value  <= d_value;
      q_enable <= d_enable;
    end
  end

endmodule

// File: rtl/bulk_pipe_ctrl.sv
// STAGES-deep registered value/enable pipeline with coherent stall/clear and a
// stall watchdog. Define BULK_PIPE_BUBBLE_COLLAPSE_EN to let bubbles squeeze out
// while the last stage is stalled.
module bulk_pipe_ctrl
  import bulk_pipe_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STAGES      = DEF_STAGES,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT,
  localparam int OCC_W      = $clog2(STAGES + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_stall,
  input  logic             ctrl_clear,
  output logic             ctrl_stuck,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_enable,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_enable,
  output logic [OCC_W-1:0] occupancy,
  output logic [1:0]       state
);

  localparam int CNT_W = $clog2(STUCK_LIMIT + 1);

  logic [WIDTH-1:0]  d_value [STAGES];
  logic [WIDTH-1:0]  q_value [STAGES];
  logic [STAGES-1:0] d_enable;
  logic [STAGES-1:0] q_enable;
  logic [STAGES-1:0] load;
  logic              blocked;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              stuck_q;

  always_comb begin
    d_value[0]  = in_value;
    d_enable[0] = in_enable;
    for (int i = 1; i < STAGES; i++) begin
      d_value[i]  = q_value[i-1];
      d_enable[i] = q_enable[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bulk_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clock    (clock),
      .reset    (reset),
      .load     (load[g]),
      .clear    (ctrl_clear),
      .d_value  (d_value[g]),
      .d_enable (d_enable[g]),
      .q_value  (q_value[g]),
      .q_enable (q_enable[g])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(q_enable[i]);
    end
  end

`ifdef BULK_PIPE_BUBBLE_COLLAPSE_EN
  // Walk from the held last stage toward stage 0: a stage advances when its
  // successor is empty or is itself advancing.
  always_comb begin
    logic move;
    load = '1;
    move = 1'b0;
    if (ctrl_stall) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        move    = !q_enable[i] || move;
        load[i] = move;
      end
      load[0] = !q_enable[0] || move;
    end
  end

  assign in_ready = !ctrl_clear && load[0];
  assign blocked  = ctrl_stall && !ctrl_clear && (occupancy == OCC_W'(STAGES));
`else
  assign load     = {STAGES{!ctrl_stall}};
  assign in_ready = !ctrl_stall && !ctrl_clear;
  assign blocked  = ctrl_stall && !ctrl_clear && (occupancy != '0);
`endif

  always_comb begin
    cnt_d   = '0;
    state_d = RUN;
    if (blocked) begin
      cnt_d   = (cnt_q == CNT_W'(STUCK_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
      state_d = (cnt_d == CNT_W'(STUCK_LIMIT)) ? STUCK : HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= RUN;
      stuck_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      stuck_q <= (state_d == STUCK);
    end
  end

  assign ctrl_stuck = stuck_q;
  assign state      = state_q;
  assign out_value  = q_value[STAGES-1];
  assign out_enable = q_enable[STAGES-1];

endmodule
